// File: rtl/stage3_fc_bias_argmax.sv
// Stage-3 classifier tail: per-class bias add + sequential argmax scan.
// Ports: clk/reset (sync, active-high), i_in_valid/i_in_acc frame strobe,
//   o_valid/i_ready result handshake, o_class/o_max_score/o_scores result,
//   o_overrun pulse when an incoming frame had to be dropped.
module stage3_fc_bias_argmax #(
  parameter int CO     = 3,
  parameter int ACC_BW = 48,
  parameter int B_BW   = 16,
  parameter int SC_BW  = ACC_BW + 1,
  parameter int CLS_BW = (CO > 1) ? $clog2(CO) : 1,
  // bias ROM image (stage3_fc1_bias.mem), class c at [c*B_BW +: B_BW]
  parameter logic [CO*B_BW-1:0] BIAS =
    {16'h0000, 16'hfffd, 16'h0005}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_in_valid,
  input  logic [CO*ACC_BW-1:0] i_in_acc,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CLS_BW-1:0]    o_class,
  output logic [SC_BW-1:0]     o_max_score,
  output logic [CO*SC_BW-1:0]  o_scores,
  output logic                 o_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t state;

  logic [CO*ACC_BW-1:0] work;
  logic [CO*ACC_BW-1:0] pend;
  logic                 pend_full;
  logic [CLS_BW-1:0]    cnt;
  logic [CLS_BW-1:0]    cls_r;
  logic signed [SC_BW-1:0] max_r;
  logic [CO*SC_BW-1:0]  sc_r;

  logic signed [ACC_BW-1:0] acc_c;
  logic signed [B_BW-1:0]   bias_c;
  logic signed [SC_BW-1:0]  score_c;

  logic hs;
  logic pop;
  logic direct;
  logic busy;
  logic last;

  always_comb begin
    acc_c   = work[cnt*ACC_BW +: ACC_BW];
    bias_c  = BIAS[cnt*B_BW +: B_BW];
    score_c = SC_BW'(acc_c) + SC_BW'(bias_c);
  end

  assign hs   = (state == OUT) && o_valid && i_ready;
  assign pop  = hs && pend_full;
  // nothing pending at the handshake: a new frame goes straight to work
  assign direct = hs && !pend_full && i_in_valid;
  assign busy = (state != IDLE);
  assign last = (cnt == CLS_BW'(CO - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      cnt         <= '0;
      cls_r       <= '0;
      max_r       <= '0;
      sc_r        <= '0;
      o_valid     <= 1'b0;
      o_class     <= '0;
      o_max_score <= '0;
      o_scores    <= '0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (i_in_valid) begin
            work  <= i_in_acc;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          sc_r[cnt*SC_BW +: SC_BW] <= score_c;
          // strict compare keeps the lowest index on ties
          if (cnt == '0 || score_c > max_r) begin
            max_r <= score_c;
            cls_r <= cnt;
          end
          if (last) begin
            state <= OUT;
          end else begin
            cnt <= cnt + CLS_BW'(1);
          end
        end
        OUT: begin
          if (!o_valid) begin
            o_valid     <= 1'b1;
            o_class     <= cls_r;
            o_max_score <= max_r;
            o_scores    <= sc_r;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            cnt     <= '0;
            if (pend_full) begin
              work  <= pend;
              state <= SCAN;
            end else if (i_in_valid) begin
              work  <= i_in_acc;
              state <= SCAN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (busy && i_in_valid && !direct) begin
        if (!pend_full || pop) begin
          pend      <= i_in_acc;
          pend_full <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (pop) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage3_fc_bias_argmax.sv
// Bench for stage3_fc_bias_argmax with bias ROM {+5, -3, 0}.
// Results are queued at stimulus time and checked at each handshake.
module tb_stage3_fc_bias_argmax;

  localparam int CO     = 3;
  localparam int ACC_BW = 48;
  localparam int SC_BW  = 49;
  localparam int CLS_BW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_in_valid;
  logic [CO*ACC_BW-1:0] i_in_acc;
  logic                 o_valid;
  logic                 i_ready;
  logic [CLS_BW-1:0]    o_class;
  logic [SC_BW-1:0]     o_max_score;
  logic [CO*SC_BW-1:0]  o_scores;
  logic                 o_overrun;

  typedef struct {
    logic [CLS_BW-1:0]   cls;
    logic [SC_BW-1:0]    mx;
    logic [CO*SC_BW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  stage3_fc_bias_argmax dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in_acc    (i_in_acc),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_class     (o_class),
    .o_max_score (o_max_score),
    .o_scores    (o_scores),
    .o_overrun   (o_overrun)
  );

  function automatic exp_t model(input longint a0, input longint a1,
                                 input longint a2);
    longint a[3];
    longint b[3];
    longint s;
    longint best;
    exp_t e;
    a[0] = a0; a[1] = a1; a[2] = a2;
    b[0] = 5;  b[1] = -3; b[2] = 0;
    best = 0;
    e.cls = '0;
    e.sc  = '0;
    for (int c = 0; c < CO; c++) begin
      s = a[c] + b[c];
      e.sc[c*SC_BW +: SC_BW] = s[SC_BW-1:0];
      if (c == 0 || s > best) begin
        best  = s;
        e.cls = CLS_BW'(c);
      end
    end
    e.mx = best[SC_BW-1:0];
    return e;
  endfunction

  task automatic strobe(input longint a0, input longint a1,
                        input longint a2, input bit keep);
    i_in_valid = 1'b1;
    i_in_acc   = {a2[47:0], a1[47:0], a0[47:0]};
    if (keep) q.push_back(model(a0, a1, a2));
  endtask

  // lat = 5 means o_valid first seen after the 4th edge past the strobe edge
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      n++;
      if (o_valid) break;
    end
  endtask

  // scoreboard: compare at every transfer edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!reset && o_valid && i_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got class=%0d max=%0d",
                   o_class, $signed(o_max_score));
        end else begin
          e = q.pop_front();
          if (o_class !== e.cls || o_max_score !== e.mx ||
              o_scores !== e.sc) begin
            errors++;
            $display("FAIL result got class=%0d max=%0d sc=%h want class=%0d max=%0d sc=%h",
                     o_class, $signed(o_max_score), o_scores,
                     e.cls, $signed(e.mx), e.sc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset;
    reset = 1'b1;
    i_in_valid = 1'b0;
    i_in_acc = '0;
    i_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", o_valid);
    end
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++; $display("FAIL rst_overrun got %b want 0", o_overrun);
    end
    checks++;
    if (o_class !== '0 || o_max_score !== '0) begin
      errors++;
      $display("FAIL rst_class got %0d/%0d want 0/0", o_class, o_max_score);
    end
    checks++;
    if (o_scores !== '0) begin
      errors++; $display("FAIL rst_scores got %h want 0", o_scores);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [CO*SC_BW-1:0] want;
    want = {49'd15, 49'd17, 49'd15};
    i_ready = 1'b1;
    strobe(10, 20, 15, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency got %0d want 4", lat - 1);
    end
    checks++;
    if (o_class !== 2'd1 || o_max_score !== 49'd17) begin
      errors++;
      $display("FAIL basic_max got %0d/%0d want 1/17", o_class, o_max_score);
    end
    checks++;
    if (o_scores !== want) begin
      errors++; $display("FAIL basic_scores got %h want %h", o_scores, want);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop got %b want 0", o_valid);
    end
  endtask

  task automatic test_tie;
    i_ready = 1'b1;
    strobe(0, 8, 5, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || o_class !== 2'd0) begin
      errors++;
      $display("FAIL tie got lat=%0d class=%0d want 5/0", lat, o_class);
    end
    @(negedge clk);
  endtask

  task automatic test_negative_width;
    i_ready = 1'b1;
    strobe(-100, -100, -100, 1'b1);
    wait_valid(lat);
    checks++;
    if (o_class !== 2'd0 || o_max_score !== -49'sd95) begin
      errors++;
      $display("FAIL negative got %0d/%0d want 0/-95",
               o_class, $signed(o_max_score));
    end
    @(negedge clk);
    strobe(64'h7fff_ffff_ffff, 0, 0, 1'b1);
    wait_valid(lat);
    checks++;
    if (o_class !== 2'd0 || o_max_score !== 49'h0_8000_0000_0004) begin
      errors++;
      $display("FAIL wide got %0d/%h want 0/0800000000004",
               o_class, o_max_score);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    i_ready = 1'b0;
    strobe(30, 1, 2, 1'b1);
    @(negedge clk);
    strobe(1, 40, 2, 1'b1);
    @(negedge clk);
    strobe(7, 7, 70, 1'b0);
    @(negedge clk);
    i_in_valid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++; $display("FAIL bp_overrun got %b want 1", o_overrun);
    end
    @(negedge clk);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++; $display("FAIL bp_overrun_pulse got %b want 0", o_overrun);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL bp_a_valid got lat=%0d want 1", lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_class !== q[0].cls ||
          o_max_score !== q[0].mx || o_scores !== q[0].sc ||
          o_overrun !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b class=%0d max=%0d want v=1 class=%0d max=%0d",
                 o_valid, o_class, o_max_score, q[0].cls, q[0].mx);
      end
    end
    i_ready = 1'b1;
    wait_valid(lat);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL bp_b_latency got %0d want 5", lat);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_valid_drop got %b want 0", o_valid);
    end
  endtask

  task automatic test_pop_collision;
    int ovr;
    int n;
    i_ready = 1'b0;
    strobe(3, 2, 1, 1'b1);
    @(negedge clk);
    strobe(-5, 9, 9, 1'b1);
    wait_valid(lat);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL pc_a_valid got %b want 1", o_valid);
    end
    i_ready = 1'b1;
    strobe(20, 0, 0, 1'b1);
    @(negedge clk);
    i_in_valid = 1'b0;
    checks++;
    if (o_overrun !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL pc_collision got ovr=%b v=%b want 0/0", o_overrun, o_valid);
    end
    ovr = 0;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (o_overrun) ovr++;
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL pc_drain got %0d left want 0", q.size());
    end
    checks++;
    if (ovr !== 0) begin
      errors++; $display("FAIL pc_no_overrun got %0d want 0", ovr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan;
    int vcount;
    i_ready = 1'b1;
    strobe(50, 60, 70, 1'b0);
    @(negedge clk);
    i_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_overrun !== 1'b0 || o_class !== '0 ||
        o_max_score !== '0 || o_scores !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b class=%0d max=%0d sc=%h want all 0",
               o_valid, o_class, o_max_score, o_scores);
    end
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++; $display("FAIL mid_reset_no_valid got %0d want 0", vcount);
    end
    strobe(1, 2, 100, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || o_class !== 2'd2) begin
      errors++;
      $display("FAIL mid_reset_next got lat=%0d class=%0d want 5/2",
               lat, o_class);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_negative_width();
    test_backpressure();
    test_pop_collision();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL final_queue got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
